// File: rtl/edge_count_scheduler.sv
// edge_count_scheduler
// One shared synchronizer-tap / edge-detect / counter datapath, scheduled
// round-robin across the enabled input channels. Each channel gets a fixed
// gate window and its count is handed out through a valid/ack result port.
module edge_count_scheduler #(
  parameter int NUM_CH        = 4,
  parameter int CH_W          = 2,
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              CLK_IN,
  input  logic              RST_N_i,
  input  logic [NUM_CH-1:0] sig_i,
  input  logic [NUM_CH-1:0] ch_enable_i,
  input  logic              run_i,
  output logic              busy_o,
  output logic [CH_W-1:0]   cur_ch_o,
  output logic              result_valid_o,
  output logic [CH_W-1:0]   result_ch_o,
  output logic [CNT_W-1:0]  result_count_o,
  output logic              result_overflow_o,
  input  logic              result_ack_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_GATE    = 3'd3;
  localparam logic [2:0] S_PUBLISH = 3'd4;

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);

  logic [NUM_CH-1:0] sync_meta;
  logic [NUM_CH-1:0] sync_q;
  logic              sel_sig;
  logic              last_sig;
  logic              edge_seen;
  logic [2:0]        state;
  logic [TMR_W-1:0]  timer;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              ovf;
  logic              ovf_next;
  logic              started;
  logic              any_en;
  logic [CH_W-1:0]   next_ch;
  logic [CH_W-1:0]   idx;
  int                base;

  assign sel_sig   = sync_q[cur_ch_o];
  assign edge_seen = !last_sig && sel_sig;
  assign any_en    = |ch_enable_i;
  assign busy_o    = (state != S_IDLE);

  // Two-stage synchronizer on every input pin, free-running
  always_ff @(posedge CLK_IN or negedge RST_N_i) begin
    if (!RST_N_i) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= sig_i;
      sync_q    <= sync_meta;
    end
  end

  // Previous value of the selected bit; refreshed every cycle so SETTLE reloads it
  always_ff @(posedge CLK_IN or negedge RST_N_i) begin
    if (!RST_N_i) begin
      last_sig <= 1'b0;
    end else begin
      last_sig <= sel_sig;
    end
  end

  // Next enabled channel after the last-measured one (from channel 0 before any pick)
  always_comb begin
    next_ch = cur_ch_o;
    idx     = '0;
    base    = started ? (int'(cur_ch_o) + 1) : 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CH_W'((base + i) % NUM_CH);
      if (ch_enable_i[idx]) begin
        next_ch = idx;
      end
    end
  end

  // Saturating counter step for the current cycle
  always_comb begin
    cnt_next = cnt;
    ovf_next = ovf;
    if (edge_seen) begin
      if (&cnt) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  // Scheduler FSM, gate timer, counter and result registers
  always_ff @(posedge CLK_IN or negedge RST_N_i) begin
    if (!RST_N_i) begin
      state             <= S_IDLE;
      timer             <= '0;
      cnt               <= '0;
      ovf               <= 1'b0;
      cur_ch_o          <= '0;
      started           <= 1'b0;
      result_valid_o    <= 1'b0;
      result_ch_o       <= '0;
      result_count_o    <= '0;
      result_overflow_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run_i && any_en) begin
            state <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (!run_i || !any_en) begin
            state <= S_IDLE;
          end else begin
            cur_ch_o <= next_ch;
            started  <= 1'b1;
            cnt      <= '0;
            ovf      <= 1'b0;
            timer    <= '0;
            state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!run_i) begin
            state <= S_IDLE;
          end else if (timer == SETTLE_LAST) begin
            timer <= '0;
            state <= S_GATE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_GATE: begin
          if (!run_i) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt_next;
            ovf <= ovf_next;
            if (timer == GATE_LAST) begin
              state             <= S_PUBLISH;
              result_valid_o    <= 1'b1;
              result_ch_o       <= cur_ch_o;
              result_count_o    <= cnt_next;
              result_overflow_o <= ovf_next;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        S_PUBLISH: begin
          if (result_ack_i) begin
            result_valid_o <= 1'b0;
            state          <= (run_i && any_en) ? S_SELECT : S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_count_scheduler.sv
// Directed bench for edge_count_scheduler: a CNT_W=8 instance for the
// scheduling scenarios and a CNT_W=5 instance for counter saturation.
module tb_edge_count_scheduler;

  logic       CLK_IN;
  logic       rst_n;
  logic [3:0] sig;
  logic [3:0] en;
  logic       run;
  logic       ack;
  logic       busy;
  logic [1:0] cur_ch;
  logic       res_valid;
  logic [1:0] res_ch;
  logic [7:0] res_count;
  logic       res_ovf;

  logic [3:0] sig_s;
  logic [3:0] en_s;
  logic       run_s;
  logic       ack_s;
  logic       busy_s;
  logic [1:0] cur_ch_s;
  logic       res_valid_s;
  logic [1:0] res_ch_s;
  logic [4:0] res_count_s;
  logic       res_ovf_s;

  int vec_count;
  int err_count;
  int half [4];
  int ph [4];
  int half_s;
  int ph_s;

  edge_count_scheduler #(
    .NUM_CH(4), .CH_W(2), .CNT_W(8), .GATE_CYCLES(100), .SETTLE_CYCLES(2)
  ) dut (
    .CLK_IN(CLK_IN), .RST_N_i(rst_n), .sig_i(sig), .ch_enable_i(en), .run_i(run),
    .busy_o(busy), .cur_ch_o(cur_ch), .result_valid_o(res_valid), .result_ch_o(res_ch),
    .result_count_o(res_count), .result_overflow_o(res_ovf), .result_ack_i(ack)
  );

  edge_count_scheduler #(
    .NUM_CH(4), .CH_W(2), .CNT_W(5), .GATE_CYCLES(100), .SETTLE_CYCLES(2)
  ) dut_s (
    .CLK_IN(CLK_IN), .RST_N_i(rst_n), .sig_i(sig_s), .ch_enable_i(en_s), .run_i(run_s),
    .busy_o(busy_s), .cur_ch_o(cur_ch_s), .result_valid_o(res_valid_s), .result_ch_o(res_ch_s),
    .result_count_o(res_count_s), .result_overflow_o(res_ovf_s), .result_ack_i(ack_s)
  );

  // 10 ns free-running clock
  initial CLK_IN = 1'b0;
  always #5 CLK_IN = ~CLK_IN;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vec_count++;
    if (got !== expv) begin
      err_count++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] e, input logic r, input logic a);
    en  = e;
    run = r;
    ack = a;
  endtask

  // One clock: advance to just after the rising edge, then step the square waves
  task automatic tick();
    @(posedge CLK_IN);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (half[k] != 0) begin
        ph[k]++;
        if (ph[k] >= half[k]) begin
          ph[k]  = 0;
          sig[k] = ~sig[k];
        end
      end
    end
    if (half_s != 0) begin
      ph_s++;
      if (ph_s >= half_s) begin
        ph_s     = 0;
        sig_s[0] = ~sig_s[0];
      end
    end
  endtask

  task automatic holdSig(input int k, input logic v);
    half[k] = 0;
    ph[k]   = 0;
    sig[k]  = v;
  endtask

  task automatic doReset();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) holdSig(k, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic waitValid(input bit sat, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if ((sat ? res_valid_s : res_valid) == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkResult(input string tag, input int ech, input int ecnt, input int eovf);
    checkOutput({tag, "_ch"}, 32'(res_ch), 32'(ech));
    checkOutput({tag, "_count"}, 32'(res_count), 32'(ecnt));
    checkOutput({tag, "_ovf"}, 32'(res_ovf), 32'(eovf));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_cur_ch"}, 32'(cur_ch), 32'd0);
    checkOutput({tag, "_valid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, "_res_ch"}, 32'(res_ch), 32'd0);
    checkOutput({tag, "_res_count"}, 32'(res_count), 32'd0);
    checkOutput({tag, "_res_ovf"}, 32'(res_ovf), 32'd0);
  endtask

  // Main directed sequence
  initial begin
    bit ok;
    int lat;
    int per;
    int bad;
    int seen;
    int exp_rr [6];
    int exp_sw [3];
    logic [1:0] held_ch;
    logic [7:0] held_cnt;

    vec_count = 0;
    err_count = 0;
    half_s = 0;
    ph_s   = 0;
    sig_s  = 4'b0000;
    en_s   = 4'b0000;
    run_s  = 1'b0;
    ack_s  = 1'b0;
    sig    = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      half[k] = 0;
      ph[k]   = 0;
    end
    applyStimulus(4'b0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    checkResetOutputs("reset");
    rst_n = 1'b1;
    tick();

    $display("[TB] basic count on ch0");
    half[0] = 5;
    applyStimulus(4'b0001, 1'b1, 1'b1);
    // the IDLE cycle in which run is first seen counts as clock 1
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      lat++;
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("first_valid_latency", 32'(lat), 32'd105);
    checkResult("basic1", 0, 10, 0);
    per = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      per++;
      if (res_valid) break;
    end
    checkOutput("steady_period", 32'(per), 32'd104);
    checkResult("basic2", 0, 10, 0);

    $display("[TB] round robin");
    doReset();
    exp_rr = '{0, 1, 3, 0, 1, 3};
    applyStimulus(4'b1011, 1'b1, 1'b1);
    for (int n = 0; n < 6; n++) begin
      waitValid(1'b0, ok);
      checkOutput($sformatf("rr_ch%0d", n), 32'(res_ch), 32'(exp_rr[n]));
    end
    for (int i = 0; i < 50; i++) tick();
    checkOutput("rr_mid_gate_ch", 32'(cur_ch), 32'd0);
    applyStimulus(4'b0100, 1'b1, 1'b1);
    exp_sw = '{0, 2, 2};
    for (int n = 0; n < 3; n++) begin
      waitValid(1'b0, ok);
      checkOutput($sformatf("switch_ch%0d", n), 32'(res_ch), 32'(exp_sw[n]));
    end

    $display("[TB] saturation");
    doReset();
    half_s = 1;
    en_s   = 4'b0001;
    ack_s  = 1'b1;
    run_s  = 1'b1;
    waitValid(1'b1, ok);
    checkOutput("sat_count", 32'(res_count_s), 32'd31);
    checkOutput("sat_ovf", 32'(res_ovf_s), 32'd1);
    half_s   = 0;
    sig_s[0] = 1'b0;
    waitValid(1'b1, ok);
    checkOutput("quiet_count", 32'(res_count_s), 32'd0);
    checkOutput("quiet_ovf", 32'(res_ovf_s), 32'd0);
    run_s = 1'b0;

    $display("[TB] false-edge suppression");
    doReset();
    holdSig(0, 1'b0);
    holdSig(1, 1'b1);
    tick();
    tick();
    tick();
    applyStimulus(4'b0011, 1'b1, 1'b1);
    for (int n = 0; n < 4; n++) begin
      waitValid(1'b0, ok);
      checkResult($sformatf("noedge%0d", n), n % 2, 0, 0);
    end

    $display("[TB] back-pressure");
    doReset();
    half[0] = 5;
    half[1] = 5;
    applyStimulus(4'b0011, 1'b1, 1'b0);
    waitValid(1'b0, ok);
    checkResult("bp_first", 0, 10, 0);
    held_ch  = cur_ch;
    held_cnt = res_count;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_ch !== 2'd0 || res_count !== held_cnt ||
          res_ovf !== 1'b0 || cur_ch !== held_ch || busy !== 1'b1) bad++;
    end
    checkOutput("bp_hold_violations", 32'(bad), 32'd0);
    ack = 1'b1;
    tick();
    checkOutput("bp_valid_drop", 32'(res_valid), 32'd0);
    ack = 1'b0;
    tick();
    checkOutput("bp_next_ch", 32'(cur_ch), 32'd1);
    waitValid(1'b0, ok);
    checkResult("bp_second", 1, 10, 0);

    $display("[TB] abort");
    doReset();
    half[0] = 5;
    applyStimulus(4'b0001, 1'b1, 1'b1);
    for (int i = 0; i < 54; i++) tick();
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    run = 1'b0;
    tick();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_valid", 32'(res_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (res_valid) seen++;
    end
    checkOutput("abort_no_result", 32'(seen), 32'd0);

    $display("[TB] reset during publish");
    applyStimulus(4'b0110, 1'b1, 1'b1);
    waitValid(1'b0, ok);
    checkOutput("rp_first_ch", 32'(res_ch), 32'd1);
    waitValid(1'b0, ok);
    checkOutput("rp_second_ch", 32'(res_ch), 32'd2);
    ack   = 1'b0;
    rst_n = 1'b0;
    #2;
    checkResetOutputs("rst_in_publish");
    #1;
    rst_n = 1'b1;
    waitValid(1'b0, ok);
    checkOutput("rp_restart_ch", 32'(res_ch), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/edge_count_scheduler.md
# edge_count_scheduler

Time-multiplexes one rising-edge counting datapath (synchronizer, edge detector, counter) across `NUM_CH` external inputs. It runs a fixed-length gate window on each enabled channel in round-robin order and publishes each count through a valid/ack result port. It sits between the FPGA input pins and whatever consumes the measurements, such as the LED display or a readout register. It replaces one free-running counter per pin with a single scheduled counter.

## Interface
- `NUM_CH`, 4: number of input channels (2..16).
- `CH_W`, 2: channel index width, must equal clog2(`NUM_CH`).
- `CNT_W`, 16: edge counter / result width.
- `GATE_CYCLES`, 1000: gate window length in clocks (≥2).
- `SETTLE_CYCLES`, 2: clocks after a channel switch before gating starts (≥1).

Ports:
- `CLK_IN`  in  1  single clock; all logic on rising edge.
- `RST_N_i`  in  1  asynchronous active-low reset.
- `sig_i`  in  NUM_CH  asynchronous input signals.
- `ch_enable_i`  in  NUM_CH  channel participates in the rotation when 1.
- `run_i`  in  1  level; scheduler rotates while high.
- `busy_o`  out  1  high in any state other than IDLE.
- `cur_ch_o`  out  CH_W  channel currently selected.
- `result_valid_o`  out  1  result fields valid.
- `result_ch_o`  out  CH_W  channel the result belongs to.
- `result_count_o`  out  CNT_W  rising edges counted in the gate.
- `result_overflow_o`  out  1  count saturated.
- `result_ack_i`  in  1  consumer accepts the result.

## Operation
- Every `sig_i` bit passes through its own 2-FF synchronizer, which runs continuously. A mux driven by `cur_ch_o` selects one synchronized bit (`sel`). A single `last` register holds the previous `sel` value. An edge is detected when `last==0 && sel==1`.
- FSM states and transitions:
  - IDLE: go to SELECT when `run_i==1` and `ch_enable_i!=0`.
  - SELECT, 1 cycle: the pointer advances to the next enabled channel after the last-measured one, wrapping. The first pick after reset is the lowest enabled channel ≥0. `cur_ch_o` updates, the counter clears, then go to SETTLE.
  - SETTLE, `SETTLE_CYCLES` cycles: `last` is reloaded from `sel` every cycle and edges are ignored. This prevents a false edge from the channel switch.
  - GATE, `GATE_CYCLES` cycles: each detected edge increments the counter.
  - PUBLISH: latch the result and assert `result_valid_o`. Hold until ack, then go to SELECT if `run_i` is high and any channel is enabled, else IDLE.
- The counter saturates at all-ones. A further edge sets the overflow flag and does not wrap.
- Enable changes are sampled only in SELECT. A channel disabled mid-gate completes its gate normally.
- `run_i` low during SELECT, SETTLE or GATE aborts to IDLE on the next edge and publishes nothing. `run_i` low during PUBLISH still waits for ack, then goes to IDLE.
- Back-pressure: no new gate starts while a result is unacknowledged, so no result is ever lost or overwritten.
- Asynchronous reset at any point forces IDLE and clears the synchronizers, the `last` register and the pointer.

## Timing
- Reset values: `busy_o`=0, `cur_ch_o`=0, `result_valid_o`=0, `result_ch_o`=0, `result_count_o`=0, `result_overflow_o`=0.
- `run_i` rising edge to the first GATE cycle: 1 (IDLE→SELECT) + 1 (SELECT) + `SETTLE_CYCLES`.
- Input-to-detect latency is 3 clocks: 2 synchronizer stages plus the `last` register. An edge is counted if its detect cycle falls inside the GATE window.
- `result_valid_o` rises in the cycle after the last GATE cycle. All result fields are registered and stable while valid is high.
- Ack handshake: ack is sampled only while `result_valid_o==1`. `result_valid_o` drops on the following edge, in the same cycle the FSM enters SELECT or IDLE. Ack while valid is low is ignored.
- Steady-state period per channel with ack tied high: 1 + `SETTLE_CYCLES` + `GATE_CYCLES` + 1 clocks.

## Test plan
Bench parameters: `NUM_CH`=4, `GATE_CYCLES`=100, `SETTLE_CYCLES`=2, `CNT_W`=8.
- Basic count: `ch_enable_i`=0001, ch0 square wave period 10 clocks, ack tied high, `run_i`=1 → every result has ch=0, count=10, overflow=0. The first valid appears 1+1+2+100+1 clocks after `run_i` rises.
- Round robin: enable=1011 → `result_ch_o` sequence 0,1,3,0,1,3. Switching enable to 0100 mid-GATE → the current gate completes, then only ch2 results follow.
- Saturation: `CNT_W`=5, ch0 period 2 clocks → count=31, overflow=1. The next gate on a channel held at 0 reports count=0, overflow=0.
- False-edge suppression: ch0 held 0, ch1 held 1, enable=0011 → both channels report count=0 forever.
- Back-pressure: ack held low for 500 clocks after the first valid → valid stays 1, fields are unchanged, `cur_ch_o` is constant and no counting occurs. One ack → valid drops the next clock and the next channel's gate starts.
- Abort and reset: `run_i` dropped at GATE cycle 50 → IDLE the next clock, `busy_o`=0, no valid. `RST_N_i` pulsed low during PUBLISH → valid=0 immediately with all outputs at reset values, and the rotation restarts at the lowest enabled channel.
